// File: rtl/read_ptr_ctrl.sv
// Read-side pointer controller for the asynchronous FIFO: binary/Gray read pointers,
// RAM read address and registered empty/almost-empty/count/underflow/pointer-error flags.
module read_ptr_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 23,
  parameter int AE_THRESH = 2,
  localparam int PTR_W    = ADDR_W + 1
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              r_en,
  input  logic [PTR_W-1:0]  g_wptr_sync,
  output logic [PTR_W-1:0]  g_rptr,
  output logic [PTR_W-1:0]  b_rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTR_W-1:0]  rd_count,
  output logic              underflow,
  output logic              ptr_err
);

  // The 2*DEPTH pointer states sit centred in the code space so LAST->OFFSET flips only the MSB
  localparam logic [PTR_W-1:0] OFFSET  = PTR_W'(((1 << PTR_W) - 2 * DEPTH) / 2);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(((1 << PTR_W) - 2 * DEPTH) / 2 + 2 * DEPTH - 1);
  localparam logic [PTR_W:0]   SPAN    = (PTR_W + 1)'(2 * DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AE_P    = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0]  r_b_rptr;
  logic [PTR_W-1:0]  r_g_rptr;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_empty;
  logic              r_almost_empty;
  logic [PTR_W-1:0]  r_rd_count;
  logic              r_underflow;
  logic              r_ptr_err;

  logic              w_rd_fire;
  logic [PTR_W-1:0]  w_b_next;
  logic [PTR_W-1:0]  w_g_next;
  logic [PTR_W-1:0]  w_rel;
  logic [ADDR_W-1:0] w_raddr_next;
  logic [PTR_W-1:0]  w_wbin;
  logic              w_bad;
  logic [PTR_W:0]    w_diff;
  logic [PTR_W:0]    w_diff_adj;
  logic [PTR_W-1:0]  w_cnt_next;
  logic              w_empty_next;
  logic              w_ae_next;

  always_comb begin
    w_rd_fire = r_en & ~r_empty;
    w_b_next  = r_b_rptr;
    if (w_rd_fire) begin
      w_b_next = (r_b_rptr == LAST) ? OFFSET : r_b_rptr + ONE;
    end
    w_g_next     = bin2gray(w_b_next);
    w_rel        = w_b_next - OFFSET;
    w_raddr_next = (w_rel >= DEPTH_P) ? ADDR_W'(w_rel - DEPTH_P) : ADDR_W'(w_rel);

    w_wbin = gray2bin(g_wptr_sync);
    w_bad  = (w_wbin < OFFSET) || (w_wbin > LAST);

    // Borrow out of the extra MSB means the write pointer has wrapped past the read pointer
    w_diff       = {1'b0, w_wbin} - {1'b0, w_b_next};
    w_diff_adj   = w_diff[PTR_W] ? (w_diff + SPAN) : w_diff;
    w_cnt_next   = w_bad ? '0 : PTR_W'(w_diff_adj);
    w_empty_next = w_bad | (g_wptr_sync == w_g_next);
    w_ae_next    = (w_cnt_next <= AE_P);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_b_rptr       <= OFFSET;
      r_g_rptr       <= bin2gray(OFFSET);
      r_raddr        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_count     <= '0;
      r_underflow    <= 1'b0;
      r_ptr_err      <= 1'b0;
    end else begin
      r_b_rptr       <= w_b_next;
      r_g_rptr       <= w_g_next;
      r_raddr        <= w_raddr_next;
      r_empty        <= w_empty_next;
      r_almost_empty <= w_ae_next;
      r_rd_count     <= w_cnt_next;
      r_underflow    <= r_underflow | (r_en & r_empty);
      r_ptr_err      <= r_ptr_err | w_bad;
    end
  end

  assign b_rptr       = r_b_rptr;
  assign g_rptr       = r_g_rptr;
  assign raddr        = r_raddr;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_count     = r_rd_count;
  assign underflow    = r_underflow;
  assign ptr_err      = r_ptr_err;

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Bench for read_ptr_ctrl: constant vector table for DEPTH=23 plus model-driven
// sequences for the wrap and for a DEPTH=5 instance, all through one scoreboard queue.
module tb_read_ptr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, ren0;
  logic [5:0] gw0, g0, b0, cnt0;
  logic [4:0] ra0;
  logic       emp0, ae0, uf0, err0;

  logic       rst1, ren1;
  logic [3:0] gw1, g1, b1, cnt1;
  logic [2:0] ra1;
  logic       emp1, ae1, uf1, err1;

  read_ptr_ctrl #(.ADDR_W(5), .DEPTH(23), .AE_THRESH(2)) dut0 (
    .rclk(clk), .rrst(rst0), .r_en(ren0), .g_wptr_sync(gw0),
    .g_rptr(g0), .b_rptr(b0), .raddr(ra0), .empty(emp0),
    .almost_empty(ae0), .rd_count(cnt0), .underflow(uf0), .ptr_err(err0)
  );

  read_ptr_ctrl #(.ADDR_W(3), .DEPTH(5), .AE_THRESH(2)) dut1 (
    .rclk(clk), .rrst(rst1), .r_en(ren1), .g_wptr_sync(gw1),
    .g_rptr(g1), .b_rptr(b1), .raddr(ra1), .empty(emp1),
    .almost_empty(ae1), .rd_count(cnt1), .underflow(uf1), .ptr_err(err1)
  );

  typedef struct {
    int inst;
    bit rst;
    bit ren;
    int wb;
    int b;
    int ra;
    int cnt;
    bit emp;
    bit ae;
    bit uf;
    bit err;
  } vec_t;

  vec_t tbl[22];
  vec_t sbq[$];
  int   nchecks = 0;
  int   nerr    = 0;

  int   m_rpos[2];
  int   m_cnt[2];
  bit   m_emp[2];
  bit   m_uf[2];
  bit   m_err[2];

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    nchecks++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic check_out(input vec_t e, input string lbl);
    int ab, ag, ara, acnt, aemp, aae, auf, aerr;
    if (e.inst == 0) begin
      ab = int'(b0); ag = int'(g0); ara = int'(ra0); acnt = int'(cnt0);
      aemp = int'(emp0); aae = int'(ae0); auf = int'(uf0); aerr = int'(err0);
    end else begin
      ab = int'(b1); ag = int'(g1); ara = int'(ra1); acnt = int'(cnt1);
      aemp = int'(emp1); aae = int'(ae1); auf = int'(uf1); aerr = int'(err1);
    end
    chk({lbl, ".b_rptr"}, ab, e.b);
    chk({lbl, ".g_rptr"}, ag, gray(e.b));
    chk({lbl, ".raddr"}, ara, e.ra);
    chk({lbl, ".rd_count"}, acnt, e.cnt);
    chk({lbl, ".empty"}, aemp, int'(e.emp));
    chk({lbl, ".almost_empty"}, aae, int'(e.ae));
    chk({lbl, ".underflow"}, auf, int'(e.uf));
    chk({lbl, ".ptr_err"}, aerr, int'(e.err));
  endtask

  // Drive on the falling edge, let one rising edge pass, compare on the next falling edge
  task automatic apply(input vec_t e, input string lbl);
    vec_t exp_e;
    if (e.inst == 0) begin
      rst0 = e.rst; ren0 = e.ren; gw0 = 6'(gray(e.wb));
    end else begin
      rst1 = e.rst; ren1 = e.ren; gw1 = 4'(gray(e.wb));
    end
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    exp_e = sbq.pop_front();
    check_out(exp_e, lbl);
  endtask

  // Reference model tracks the read position as an index 0..2D-1 and the fill level directly
  task automatic mstep(input int inst, input bit rst, input bit ren, input int wb, output vec_t e);
    int d, off;
    d   = (inst != 0) ? 5 : 23;
    off = (inst != 0) ? 3 : 9;
    if (rst) begin
      m_rpos[inst] = 0; m_cnt[inst] = 0; m_emp[inst] = 1'b1;
      m_uf[inst] = 1'b0; m_err[inst] = 1'b0;
    end else begin
      if (ren && m_emp[inst]) m_uf[inst] = 1'b1;
      if (ren && !m_emp[inst]) m_rpos[inst] = (m_rpos[inst] + 1) % (2 * d);
      if (wb < off || wb > off + 2 * d - 1) begin
        m_err[inst] = 1'b1;
        m_cnt[inst] = 0;
      end else begin
        m_cnt[inst] = ((wb - off) - m_rpos[inst] + 2 * d) % (2 * d);
      end
      m_emp[inst] = (m_cnt[inst] == 0);
    end
    e = '{inst, rst, ren, wb, off + m_rpos[inst], m_rpos[inst] % d, m_cnt[inst],
          m_emp[inst], (m_cnt[inst] <= 2), m_uf[inst], m_err[inst]};
  endtask

  initial begin
    vec_t e;
    int   gprev, pb, wrap_seen, maxc, wpos, wb;
    bit   ren;

    rst0 = 1'b1; ren0 = 1'b0; gw0 = 6'b001101;
    rst1 = 1'b1; ren1 = 1'b0; gw1 = 4'b0010;

    //          inst rst ren wb   b  ra cnt emp ae uf err
    tbl[0]  = '{0, 1, 0,  9,  9, 0, 0, 1, 1, 0, 0};
    tbl[1]  = '{0, 0, 0,  9,  9, 0, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 10,  9, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 11,  9, 0, 2, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 12,  9, 0, 3, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 13,  9, 0, 4, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 14,  9, 0, 5, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 14, 10, 1, 4, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 14, 11, 2, 3, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 14, 12, 3, 2, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 1, 14, 13, 4, 1, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 1, 14, 14, 5, 0, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 14, 14, 5, 0, 1, 1, 1, 0};
    tbl[13] = '{0, 1, 0, 14,  9, 0, 0, 1, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 12,  9, 0, 3, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 1, 13, 10, 1, 3, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 13, 10, 1, 3, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 60, 10, 1, 0, 1, 1, 0, 1};
    tbl[18] = '{0, 0, 0, 13, 10, 1, 3, 0, 0, 0, 1};
    tbl[19] = '{0, 0, 1, 13, 11, 2, 2, 0, 1, 0, 1};
    tbl[20] = '{0, 0, 1,  2, 12, 3, 0, 1, 1, 0, 1};
    tbl[21] = '{0, 1, 0,  9,  9, 0, 0, 1, 1, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Walk the DEPTH=23 read pointer up to LAST one word at a time, then wrap it
    mstep(0, 1'b1, 1'b0, 9, e); apply(e, "wrap_rst");
    mstep(0, 1'b0, 1'b0, 9, e); apply(e, "wrap_rel");
    for (int k = 0; k < 45; k++) begin
      mstep(0, 1'b0, 1'b0, 10 + k, e); apply(e, $sformatf("walk_w%0d", k));
      mstep(0, 1'b0, 1'b1, 10 + k, e); apply(e, $sformatf("walk_r%0d", k));
    end
    mstep(0, 1'b0, 1'b0, 10, e); apply(e, "wrap_cnt2");
    gprev = int'(g0);
    mstep(0, 1'b0, 1'b1, 10, e); apply(e, "wrap_rd1");
    chk("wrap_gray_msb_only", gprev ^ int'(g0), 32);
    mstep(0, 1'b0, 1'b1, 10, e); apply(e, "wrap_rd2");

    // DEPTH=5 instance: writer never overfills, reader pulses every other cycle
    mstep(1, 1'b1, 1'b0, 3, e); apply(e, "d5_rst");
    mstep(1, 1'b0, 1'b0, 3, e); apply(e, "d5_rel");
    wrap_seen = 0; maxc = 0; wpos = 0;
    for (int i = 0; i < 60; i++) begin
      if ((i % 3) != 2 && m_cnt[1] < 5) wpos = (wpos + 1) % 10;
      wb  = 3 + wpos;
      ren = (i % 2) == 1;
      pb  = int'(b1);
      mstep(1, 1'b0, ren, wb, e); apply(e, $sformatf("d5_%0d", i));
      if (pb == 12 && int'(b1) == 3) wrap_seen++;
      if (int'(cnt1) > maxc) maxc = int'(cnt1);
    end
    chk("d5_wrap_12_to_3_seen", int'(wrap_seen > 0), 1);
    chk("d5_rd_count_le_5", int'(maxc <= 5), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/read_ptr_ctrl.md
# read_ptr_ctrl

Parametrised read-side pointer controller for the asynchronous FIFO. It runs in the read clock domain and owns the binary and Gray read pointers, including the read address. It derives the registered empty, almost-empty, fill count, underflow and pointer-error flags from the synchronised Gray write pointer. Any even pointer range is supported (2·DEPTH states, centred in the 2^PTR_W code space) so non-power-of-two depths keep single-bit Gray transitions on wrap. It is the successor of the fixed 9..54 read pointer handler and is drop-in for DEPTH=23, ADDR_W=5.

## Interface
- ADDR_W, 5, address width; PTR_W = ADDR_W+1 (derived)
- DEPTH, 23, FIFO words; 2 ≤ DEPTH ≤ 2^ADDR_W
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH
- OFFSET (derived) = (2^PTR_W − 2·DEPTH)/2; LAST (derived) = OFFSET + 2·DEPTH − 1
- rclk  in  1  read clock
- rrst  in  1  asynchronous, active-high reset
- r_en  in  1  read request
- g_wptr_sync  in  PTR_W  Gray write pointer, already 2-FF synchronised into rclk
- g_rptr  out  PTR_W  registered Gray read pointer (to write-side synchroniser)
- b_rptr  out  PTR_W  registered binary read pointer, range OFFSET..LAST
- raddr  out  ADDR_W  registered RAM read address, 0..DEPTH−1
- empty  out  1  registered empty flag
- almost_empty  out  1  registered, count ≤ AE_THRESH
- rd_count  out  PTR_W  registered words available to read, 0..DEPTH
- underflow  out  1  sticky: read requested while empty
- ptr_err  out  1  sticky: decoded write pointer outside OFFSET..LAST

## Operation
- rd_fire = r_en & ~empty.
- b_rptr_next = OFFSET if (b_rptr == LAST & rd_fire); b_rptr+1 if rd_fire; else b_rptr. There is no unconditional wrap: the pointer holds at LAST until a read fires.
- g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1).
- raddr_next = (b_rptr_next − OFFSET), minus DEPTH if ≥ DEPTH.
- wbin = Gray-to-binary(g_wptr_sync), computed combinationally using an XOR prefix from the MSB.
- diff = wbin − b_rptr_next; add 2·DEPTH if negative. This gives rd_count_next, in the range 0..DEPTH.
- empty_next = (g_wptr_sync == g_rptr_next). This is equivalent to rd_count_next == 0.
- almost_empty_next = rd_count_next ≤ AE_THRESH.
- underflow is set on r_en & empty and cleared only by reset. The pointer does not move.
- ptr_err is set when wbin < OFFSET or wbin > LAST, and cleared only by reset. While wbin is out of range, rd_count is forced to 0 and empty to 1.
- All outputs update together from the _next values on each rclk edge.

## Timing
- Reset (async assert, sync release):
  - b_rptr = OFFSET, g_rptr = gray(OFFSET), raddr = 0
  - empty = 1, almost_empty = 1, rd_count = 0
  - underflow = 0, ptr_err = 0
- Read latency: a read with r_en high at edge N (empty low) advances b_rptr, g_rptr and raddr at edge N. The RAM samples the raddr that was valid before edge N.
- Flag latency: g_wptr_sync change → empty, almost_empty and rd_count update on the next rclk edge. There is no additional pipeline.
- Wrap: LAST → OFFSET is a one-bit Gray change (MSB only), guaranteed by the symmetric offset.
- Simultaneous read and write-pointer advance in the same cycle: rd_count is net unchanged and empty stays low.
- Last word: a read with rd_count = 1 and no write arrival gives empty = 1 on the same edge that the pointer advances.
- Reset mid-operation: all state returns to reset values immediately, and any pending r_en is ignored until rrst deasserts.

## Test plan
- **Reset.** Conditions: DEPTH=23, rrst pulsed with g_wptr_sync = 6'b001101. Required response: b_rptr=9, g_rptr=6'b001101, raddr=0, empty=1, rd_count=0, flags 0.
- **Fill and drain.** Stimulus: step g_wptr_sync gray(9)→gray(14), then r_en high for 6 cycles. Required response:
  - rd_count goes 5, 4, 3, 2, 1, 0.
  - almost_empty asserts at count 2.
  - empty asserts after the 5th read.
  - underflow sets on the 6th read and b_rptr holds at 14.
- **Wrap.** Conditions: b_rptr=54, write pointer gray(10) (count 2). Stimulus: r_en for 2 cycles. Required response:
  - b_rptr goes 54→9→10.
  - g_rptr goes 6'b101101→6'b001101, an MSB-only change.
  - raddr goes 22→0→1.
  - empty=1 at the end.
- **Simultaneous.** Conditions: count 3. Stimulus: a read and a write-pointer increment in the same cycle. Required response: rd_count stays 3 and empty stays 0.
- **Pointer error.** Stimulus: g_wptr_sync=gray(60). Required response: ptr_err=1 next edge and stays set; rd_count=0; empty=1.
- **Non-default parameters.** Conditions: ADDR_W=3, DEPTH=5, giving OFFSET=3 and LAST=12. Required response:
  - A full cycle of 10 reads/writes wraps 12→3.
  - rd_count never exceeds 5.
